mont_exp_ctrl: RTL

//  Sequencer for one Montgomery core: computes o_result = base^exp mod N by

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_exp_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation sequencer.
package mont_pkg;

   localparam int MONT_W = 256;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SCAN      = 3'd1,
      ST_SQR_ISSUE = 3'd2,
      ST_SQR_WAIT  = 3'd3,
      ST_MUL_ISSUE = 3'd4,
      ST_MUL_WAIT  = 3'd5,
      ST_OUT_ISSUE = 3'd6,
      ST_OUT_WAIT  = 3'd7
   } state_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a single Montgomery core,
// finishing with a multiply by 1 to return the result to the normal domain.
//
// state     | meaning
// IDLE      | waiting for i_start
// SCAN      | skipping leading zero exponent bits, acc takes base at first one
// SQR_ISSUE | start acc*acc
// SQR_WAIT  | waiting for square result
// MUL_ISSUE | start acc*base
// MUL_WAIT  | waiting for multiply result
// OUT_ISSUE | start acc*1 to leave the Montgomery domain
// OUT_WAIT  | waiting for final result, then pulse o_done
module mont_exp_ctrl
   import mont_pkg::*;
#(
   parameter int W     = MONT_W,
   parameter int EXP_W = MONT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [W-1:0]     i_N,
   input  logic [W-1:0]     i_base_mont,
   input  logic [W-1:0]     i_one_mont,
   input  logic [EXP_W-1:0] i_exp,
   output logic             o_busy,
   output logic             o_done,
   output logic [W-1:0]     o_result,
   output logic             o_mm_start,
   output logic [W-1:0]     o_mm_N,
   output logic [W-1:0]     o_mm_a,
   output logic [W-1:0]     o_mm_b,
   input  logic [W-1:0]     i_mm_result,
   input  logic             i_mm_finished
);

   localparam int IDX_W = $clog2(EXP_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);
   localparam logic [W-1:0]     ONE_W   = W'(1);

   state_t             state_q, state_d;
   logic [W-1:0]       n_q, n_d;
   logic [W-1:0]       base_q, base_d;
   logic [W-1:0]       acc_q, acc_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [W-1:0]       result_q, result_d;
   logic               mm_start_q, mm_start_d;
   logic [W-1:0]       mm_a_q, mm_a_d;
   logic [W-1:0]       mm_b_q, mm_b_d;

   logic               cur_bit;
   logic               last_bit;
   logic [IDX_W-1:0]   next_idx;

   assign cur_bit  = exp_q[bit_idx_q];
   assign last_bit = (bit_idx_q == '0);
   assign next_idx = bit_idx_q - IDX_W'(1);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      base_d     = base_q;
      acc_d      = acc_q;
      exp_d      = exp_q;
      bit_idx_d  = bit_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      mm_start_d = 1'b0;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               n_d       = i_N;
               base_d    = i_base_mont;
               exp_d     = i_exp;
               acc_d     = i_one_mont;
               bit_idx_d = IDX_TOP;
               busy_d    = 1'b1;
               state_d   = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // The leading one needs no multiply: acc simply becomes base.
            if (cur_bit) acc_d = base_q;
            if (last_bit) begin
               state_d = ST_OUT_ISSUE;
            end else begin
               bit_idx_d = next_idx;
               state_d   = cur_bit ? ST_SQR_ISSUE : ST_SCAN;
            end
         end
         ST_SQR_ISSUE: begin
            mm_a_d     = acc_q;
            mm_b_d     = acc_q;
            mm_start_d = 1'b1;
            state_d    = ST_SQR_WAIT;
         end
         ST_SQR_WAIT: begin
            if (i_mm_finished) begin
               acc_d = i_mm_result;
               if (cur_bit) begin
                  state_d = ST_MUL_ISSUE;
               end else if (last_bit) begin
                  state_d = ST_OUT_ISSUE;
               end else begin
                  bit_idx_d = next_idx;
                  state_d   = ST_SQR_ISSUE;
               end
            end
         end
         ST_MUL_ISSUE: begin
            mm_a_d     = acc_q;
            mm_b_d     = base_q;
            mm_start_d = 1'b1;
            state_d    = ST_MUL_WAIT;
         end
         ST_MUL_WAIT: begin
            if (i_mm_finished) begin
               acc_d = i_mm_result;
               if (last_bit) begin
                  state_d = ST_OUT_ISSUE;
               end else begin
                  bit_idx_d = next_idx;
                  state_d   = ST_SQR_ISSUE;
               end
            end
         end
         ST_OUT_ISSUE: begin
            mm_a_d     = acc_q;
            mm_b_d     = ONE_W;
            mm_start_d = 1'b1;
            state_d    = ST_OUT_WAIT;
         end
         ST_OUT_WAIT: begin
            if (i_mm_finished) begin
               result_d = i_mm_result;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         base_q     <= '0;
         acc_q      <= '0;
         exp_q      <= '0;
         bit_idx_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         mm_start_q <= 1'b0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         base_q     <= base_d;
         acc_q      <= acc_d;
         exp_q      <= exp_d;
         bit_idx_q  <= bit_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         mm_start_q <= mm_start_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_result   = result_q;
   assign o_mm_start = mm_start_q;
   assign o_mm_N     = n_q;
   assign o_mm_a     = mm_a_q;
   assign o_mm_b     = mm_b_q;

endmodule
